// File: rtl/switch_pkg.sv
// Shared switch-core types: MAC address type, table entry view and multicast helper.
package switch_pkg;

  typedef logic [47:0] mac_address_t;

  localparam int MAC_PORT_WIDTH = 8;
  localparam int MAC_AGE_WIDTH  = 16;

  // Wide-field view of one table entry, used for exchange with other switch blocks.
  typedef struct packed {
    logic                      valid;
    mac_address_t              key;
    logic [MAC_PORT_WIDTH-1:0] port;
    logic [MAC_AGE_WIDTH-1:0]  age;
  } mac_table_entry_t;

  localparam mac_address_t BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // The I/G bit is the LSB of the first-transmitted octet.
  function automatic logic is_multicast(input logic [7:0] first_octet);
    return first_octet[0];
  endfunction

endpackage

// File: rtl/age_tick_generator.sv
// Free-running prescaler: counts 0..TICK_CYCLES-1 and pulses tick on the wrap cycle.
module age_tick_generator #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_q;

  assign tick = (count_q == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count_q <= '0;
    else if (tick) count_q <= '0;
    else           count_q <= count_q + CW'(1);
  end

endmodule

// File: rtl/mac_address_table.sv
// MAC learning/forwarding table with learn, station move, per-port flush and multicast flood.
// Optional entry aging is built when MAC_ADDRESS_TABLE_AGING_EN is defined.
module mac_address_table
  import switch_pkg::*;
#(
  parameter int KEY_WIDTH       = 48,
  parameter int TABLE_DEPTH     = 32,
  parameter int NUMBER_OF_PORTS = 2,
  parameter int AGE_TICK_CYCLES = 50_000_000,
  parameter int AGE_LIMIT       = 300,
  localparam int PW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1,
  localparam int CW = $clog2(TABLE_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 lookup_enable,
  input  logic [KEY_WIDTH-1:0] lookup_key,
  input  logic                 learn_enable,
  input  logic [KEY_WIDTH-1:0] learn_key,
  input  logic [PW-1:0]        learn_port,
  input  logic                 flush_enable,
  input  logic [PW-1:0]        flush_port,
  output logic [PW-1:0]        match_index,
  output logic                 match_valid,
  output logic                 no_match,
  output logic                 learn_done,
  output logic                 learn_dropped,
  output logic [CW-1:0]        entry_count
);

  localparam int IW = $clog2(TABLE_DEPTH);

  logic [TABLE_DEPTH-1:0] valid_q, valid_d;
  logic [TABLE_DEPTH-1:0] lookup_hit, learn_hit, flush_kill, expire_kill;
  logic [KEY_WIDTH-1:0]   key_q [TABLE_DEPTH];
  logic [PW-1:0]          port_q [TABLE_DEPTH];
  logic [PW-1:0]          hit_port;
  logic [IW-1:0]          hit_idx, free_idx, learn_idx;
  logic                   lookup_mc, learn_mc, lookup_any, learn_any;
  logic                   free_found, learn_write;
  logic [CW-1:0]          count_d;

  assign lookup_mc = is_multicast(lookup_key[KEY_WIDTH-1 -: 8]);
  assign learn_mc  = is_multicast(learn_key[KEY_WIDTH-1 -: 8]);

  // Learn never duplicates a key, so at most one entry hits and OR-reduction selects it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    lookup_hit = '0;
    learn_hit  = '0;
    flush_kill = '0;
    hit_port   = '0;
    hit_idx    = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      lookup_hit[i] = valid_q[i] && (key_q[i] == lookup_key);
      learn_hit[i]  = valid_q[i] && (key_q[i] == learn_key);
      flush_kill[i] = flush_enable && valid_q[i] && (port_q[i] == flush_port);
      if (lookup_hit[i]) hit_port = hit_port | port_q[i];
      if (learn_hit[i])  hit_idx  = hit_idx | IW'(i);
    end
  end

  // Lowest-index free slot, searched on pre-update valid bits.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign lookup_any  = |lookup_hit;
  assign learn_any   = |learn_hit;
  assign learn_write = learn_enable && !learn_mc && (learn_any || free_found);
  assign learn_idx   = learn_any ? hit_idx : free_idx;

`ifdef MAC_ADDRESS_TABLE_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);

  logic          tick;
  logic [AW-1:0] age_q [TABLE_DEPTH];

  age_tick_generator #(
    .TICK_CYCLES(AGE_TICK_CYCLES)
  ) u_age_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );

  always_comb begin
    expire_kill = '0;
    for (int i = 0; i < TABLE_DEPTH; i++)
      expire_kill[i] = tick && valid_q[i] && (age_q[i] == AW'(AGE_LIMIT - 1));
  end

  // A learn's age reset takes priority over a same-cycle tick.
  always_ff @(posedge clock) begin
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (learn_write && (learn_idx == IW'(i)))
        age_q[i] <= '0;
      else if (tick && valid_q[i] && (age_q[i] != AW'(AGE_LIMIT)))
        age_q[i] <= age_q[i] + AW'(1);
    end
  end
`else
  localparam int unused_age_cfg = AGE_TICK_CYCLES + AGE_LIMIT;

  assign expire_kill = '0;
`endif

  // Flush and expiry clear first; a learn then (re)validates its target.
  always_comb begin
    valid_d = valid_q & ~flush_kill & ~expire_kill;
    if (learn_write) valid_d[learn_idx] = 1'b1;
    count_d = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) count_d = count_d + CW'(valid_d[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      valid_q       <= '0;
      entry_count   <= '0;
      match_index   <= '0;
      match_valid   <= 1'b0;
      no_match      <= 1'b0;
      learn_done    <= 1'b0;
      learn_dropped <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      entry_count   <= count_d;
      match_valid   <= lookup_enable && !lookup_mc && lookup_any;
      no_match      <= lookup_enable && (lookup_mc || !lookup_any);
      learn_done    <= learn_enable;
      learn_dropped <= learn_enable && !learn_mc && !learn_any && !free_found;
      if (lookup_enable && !lookup_mc && lookup_any) match_index <= hit_port;
    end
  end

  // NOTE: key/port storage is only ever read behind valid_q, so it is left unreset like a RAM.
  always_ff @(posedge clock) begin
    if (learn_write) begin
      key_q[learn_idx]  <= learn_key;
      port_q[learn_idx] <= learn_port;
    end
  end

endmodule

// File: tb/tb_mac_address_table.sv
// Self-checking bench for mac_address_table: a key->port map model checked every cycle,
// plus directed scenarios with literal expectations. Aging scenarios need MAC_ADDRESS_TABLE_AGING_EN.
module tb_mac_address_table;
  import switch_pkg::*;

  localparam int DEPTH = 32;
  localparam int PORTS = 2;
  localparam int PW    = 1;
  localparam int CW    = 6;
  localparam int TICK  = 10;
  localparam int LIMIT = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          lookup_enable = 1'b0, learn_enable = 1'b0, flush_enable = 1'b0;
  logic [47:0]   lookup_key = '0, learn_key = '0;
  logic [PW-1:0] learn_port = '0, flush_port = '0;
  logic [PW-1:0] match_index;
  logic          match_valid, no_match, learn_done, learn_dropped;
  logic [CW-1:0] entry_count;

  always #5 clock = ~clock;

  mac_address_table #(
    .KEY_WIDTH      (48),
    .TABLE_DEPTH    (DEPTH),
    .NUMBER_OF_PORTS(PORTS),
    .AGE_TICK_CYCLES(TICK),
    .AGE_LIMIT      (LIMIT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_enable(lookup_enable),
    .lookup_key   (lookup_key),
    .learn_enable (learn_enable),
    .learn_key    (learn_key),
    .learn_port   (learn_port),
    .flush_enable (flush_enable),
    .flush_port   (flush_port),
    .match_index  (match_index),
    .match_valid  (match_valid),
    .no_match     (no_match),
    .learn_done   (learn_done),
    .learn_dropped(learn_dropped),
    .entry_count  (entry_count)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model: a key->port map with per-key age ----------------
  int unsigned m_port [logic [47:0]];
  int unsigned m_age  [logic [47:0]];
  int unsigned m_cycle = 0;
  logic          e_match_valid = 0, e_no_match = 0, e_learn_done = 0, e_learn_dropped = 0;
  logic [PW-1:0] e_match_index = '0;
  int unsigned   e_count = 0;

  task automatic model_step();
    logic [47:0] keys [$];
    bit known, full;
    e_match_valid = 0;
    e_no_match    = 0;
    if (lookup_enable) begin
      if (!lookup_key[40] && m_port.exists(lookup_key)) begin
        e_match_valid = 1;
        e_match_index = PW'(m_port[lookup_key]);
      end else e_no_match = 1;
    end
    known = m_port.exists(learn_key);
    full  = (m_port.num() == DEPTH);
    e_learn_done    = learn_enable;
    e_learn_dropped = learn_enable && !learn_key[40] && !known && full;
    if (flush_enable) begin
      foreach (m_port[k]) keys.push_back(k);
      foreach (keys[j]) if (m_port[keys[j]] == flush_port) begin
        m_port.delete(keys[j]);
        m_age.delete(keys[j]);
      end
    end
`ifdef MAC_ADDRESS_TABLE_AGING_EN
    if (m_cycle % TICK == TICK - 1) begin
      keys.delete();
      foreach (m_port[k]) keys.push_back(k);
      foreach (keys[j]) begin
        m_age[keys[j]]++;
        if (m_age[keys[j]] == LIMIT) begin
          m_port.delete(keys[j]);
          m_age.delete(keys[j]);
        end
      end
    end
    m_cycle++;
`endif
    if (learn_enable && !learn_key[40] && (known || !full)) begin
      m_port[learn_key] = learn_port;
      m_age[learn_key]  = 0;
    end
    e_count = m_port.num();
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_port.delete();
      m_age.delete();
      m_cycle = 0;
      e_match_valid = 0; e_no_match = 0; e_learn_done = 0; e_learn_dropped = 0;
      e_match_index = '0; e_count = 0;
    end else model_step();
  end

  always @(negedge clock) begin
    check("match_valid",   match_valid,   e_match_valid);
    check("no_match",      no_match,      e_no_match);
    check("match_index",   match_index,   e_match_index);
    check("learn_done",    learn_done,    e_learn_done);
    check("learn_dropped", learn_dropped, e_learn_dropped);
    check("entry_count",   entry_count,   e_count);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cycle();
    @(posedge clock);
    #1;
    lookup_enable = 0;
    learn_enable  = 0;
    flush_enable  = 0;
  endtask

  task automatic learn(input logic [47:0] k, input logic [PW-1:0] p);
    learn_enable = 1; learn_key = k; learn_port = p;
    do_cycle();
  endtask

  task automatic lookup(input logic [47:0] k);
    lookup_enable = 1; lookup_key = k;
    do_cycle();
  endtask

  task automatic flush(input logic [PW-1:0] p);
    flush_enable = 1; flush_port = p;
    do_cycle();
  endtask

  localparam logic [47:0] KEY_A  = 48'h0011_2233_4455;
  localparam logic [47:0] KEY_MC = 48'h0100_5E00_0001;
  localparam logic [47:0] KEY_B  = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] KEY_C  = 48'h00AA_BBCC_DDEE;
  localparam logic [47:0] FILL   = 48'h0200_0000_0000;
  localparam logic [47:0] KEY_33 = 48'h0200_0000_00FF;

  initial begin
    int first_miss, count_zero;

    repeat (3) do_cycle();
    check("reset_count", entry_count, 0);
    check("reset_learn_done", learn_done, 0);
    reset_n = 1;

    // Learn and lookup
    learn(KEY_A, 1);
    check("learn_a_done", learn_done, 1);
    check("learn_a_count", entry_count, 1);
    lookup(KEY_A);
    check("lookup_a_hit", match_valid, 1);
    check("lookup_a_port", match_index, 1);

    // Multicast
    lookup(BROADCAST_MAC);
    check("bcast_flood", no_match, 1);
    check("bcast_no_hit", match_valid, 0);
    learn(KEY_MC, 0);
    check("mc_learn_done", learn_done, 1);
    check("mc_learn_count", entry_count, 1);

    // Full table
    for (int i = 1; i < DEPTH; i++) learn(FILL | 48'(i), 1);
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("full_count", entry_count, 32);
`endif
    learn(KEY_33, 1);
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("full_dropped", learn_dropped, 1);
    check("full_done", learn_done, 1);
    check("full_count_after", entry_count, 32);
`endif
    lookup(KEY_33);
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("key33_flood", no_match, 1);
`endif

    // Station move while full, then flush port 0
    learn(KEY_A, 0);
    lookup(KEY_A);
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("move_port", match_index, 0);
    check("move_count", entry_count, 32);
`endif
    flush(0);
    lookup(KEY_A);
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("flush_a_miss", no_match, 1);
    check("flush_count", entry_count, 31);
`endif
    lookup(FILL | 48'd1);
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("flush_keep_p1", match_valid, 1);
`endif

    // Same-cycle flush + learn + lookup
    flush_enable = 1; flush_port = 1;
    learn_enable = 1; learn_key = KEY_B; learn_port = 1;
    lookup_enable = 1; lookup_key = FILL | 48'd2;
    do_cycle();
`ifndef MAC_ADDRESS_TABLE_AGING_EN
    check("same_cycle_old_hit", match_valid, 1);
    check("same_cycle_count", entry_count, 1);
`endif
    lookup(KEY_B);
    check("b_survives", match_valid, 1);
    lookup(FILL | 48'd2);
    check("old_p1_gone", no_match, 1);

    // Mid-operation asynchronous reset
    #2 reset_n = 0;
    #1 check("midreset_count", entry_count, 0);
    check("midreset_no_match", no_match, 0);
    do_cycle();
    reset_n = 1;
    lookup(KEY_B);
    check("after_reset_miss", no_match, 1);

`ifdef MAC_ADDRESS_TABLE_AGING_EN
    // Aging: C learned at post-reset edge 0; ticks at edges 9, 19, 29.
    reset_n = 0; do_cycle(); reset_n = 1;
    learn(KEY_C, 0);
    first_miss = -1; count_zero = -1;
    for (int i = 1; i <= 40; i++) begin
      lookup(KEY_C);
      if (!match_valid && first_miss < 0) first_miss = i;
      if (entry_count == 0 && count_zero < 0) count_zero = i;
    end
    check("age_first_miss", 64'(first_miss), 30);
    check("age_count_drop", 64'(count_zero), 29);

    // Relearn at edge 25 resets age: expiry moves to the tick at edge 49.
    reset_n = 0; do_cycle(); reset_n = 1;
    learn(KEY_C, 0);
    first_miss = -1;
    for (int i = 1; i <= 55; i++) begin
      lookup_enable = 1; lookup_key = KEY_C;
      if (i == 25) begin learn_enable = 1; learn_key = KEY_C; learn_port = 0; end
      do_cycle();
      if (!match_valid && first_miss < 0) first_miss = i;
    end
    check("relearn_first_miss", 64'(first_miss), 50);
`endif

    repeat (2) do_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
